mem_port_arbiter: RTL and testbench

Arbitrates one single-ported, 32-bit, byte-write-enabled memory between the pipelined CPU's instruction-fetch requester and its data (load/store) requester, replacing the dual read-port memory model. It issues at most one access per cycle with data-side priority and bounded fetch starvation. It tags each issued read so the 1-cycle-latency read data returns to the correct requester, and it drops fetch responses killed by a pipeline flush.

---
 rtl/mem_port_arbiter.sv | 55 +++++
 tb/tb_mem_port_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data requesters
// with data priority, bounded fetch starvation and tagged 1-cycle read responses.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] streak;
  logic       if_tag, d_tag, if_ok;
  always_comb begin
    if_ok     = if_req & ~flush & ~rst;
    d_gnt     = d_req & ~rst & ~(if_ok & (streak == LIM));
    if_gnt    = if_ok & ~d_gnt;
    mem_en    = if_gnt | d_gnt;
    mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
    mem_we    = d_gnt ? d_we : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
  end
  assign if_rvalid = if_tag & ~flush;
  assign d_rvalid  = d_tag;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  // streak only counts data grants that actually made a live fetch wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_tag <= 1'b0;
      d_tag  <= 1'b0;
      streak <= '0;
    end else begin
      if_tag <= if_gnt;
      d_tag  <= d_gnt & (d_we == 4'd0);
      streak <= (if_gnt | ~if_req | flush) ? 4'd0 : ((d_gnt && streak < LIM) ? streak + 4'd1 : streak);
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of grant order, response tagging, flush and reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        if_req = 1'b0, if_gnt, if_rvalid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        d_req = 1'b0, d_gnt, d_rvalid;
  logic [3:0]  d_we = '0, mem_we;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  int vec = 0, err = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // unwritten words read as 0xA0000000 | word index
  logic [31:0] wmem [int];
  function automatic logic [31:0] rd(input logic [31:0] a);
    return wmem.exists(int'(a[31:2])) ? wmem[int'(a[31:2])] : (32'hA000_0000 | (a >> 2));
  endfunction
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'd0) mem_rdata <= rd(mem_addr);
      else begin
        logic [31:0] cur;
        cur = rd(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_we[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
        wmem[int'(mem_addr[31:2])] = cur;
      end
    end
  end

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h80;
    @(negedge clk); #1;
    vec++; if (if_gnt !== 1'b0) begin err++; $display("FAIL rst_if_gnt got=%h exp=0", if_gnt); end
    vec++; if (d_gnt !== 1'b0) begin err++; $display("FAIL rst_d_gnt got=%h exp=0", d_gnt); end
    vec++; if (mem_en !== 1'b0) begin err++; $display("FAIL rst_mem_en got=%h exp=0", mem_en); end
    vec++; if (mem_we !== 4'h0) begin err++; $display("FAIL rst_mem_we got=%h exp=0", mem_we); end
    vec++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin err++; $display("FAIL rst_rvalid got=%b%b exp=00", if_rvalid, d_rvalid); end
    @(negedge clk); rst = 1'b0; d_req = 1'b0; #1;
    vec++; if (if_gnt !== 1'b1) begin err++; $display("FAIL rel_if_gnt got=%h exp=1", if_gnt); end
    vec++; if (mem_addr !== 32'h40) begin err++; $display("FAIL rel_mem_addr got=%h exp=00000040", mem_addr); end
    @(negedge clk); rst = 1'b1; #1;
    vec++; if (if_rvalid !== 1'b0) begin err++; $display("FAIL midrst_if_rvalid got=%h exp=0", if_rvalid); end
    vec++; if (if_gnt !== 1'b0 || mem_en !== 1'b0) begin err++; $display("FAIL midrst_gnt got=%b%b exp=00", if_gnt, mem_en); end
    vec++; if (mem_addr !== 32'h0) begin err++; $display("FAIL midrst_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0; if_addr = 32'h123; d_addr = 32'h456; d_we = 4'hF; d_wdata = 32'hFFFF_FFFF;
      #1;
      vec++; if (mem_en !== 1'b0) begin err++; $display("FAIL idle_mem_en got=%h exp=0", mem_en); end
      vec++; if (mem_addr !== 32'h0) begin err++; $display("FAIL idle_mem_addr got=%h exp=0", mem_addr); end
      vec++; if (mem_we !== 4'h0) begin err++; $display("FAIL idle_mem_we got=%h exp=0", mem_we); end
      vec++; if (mem_wdata !== 32'h0) begin err++; $display("FAIL idle_mem_wdata got=%h exp=0", mem_wdata); end
      vec++; if (dut.streak !== 4'd0) begin err++; $display("FAIL idle_streak got=%0d exp=0", dut.streak); end
    end
  endtask

  task automatic test_contention();
    logic [9:0] pat;
    logic pd, pf;
    pat = 10'b0111101111;
    pd = 1'b0; pf = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if_req = (i < 10); d_req = (i < 10); d_we = 4'h0; if_addr = 32'h40; d_addr = 32'h80;
      #1;
      if (i < 10) begin
        vec++; if (d_gnt !== pat[i]) begin err++; $display("FAIL cont_d_gnt[%0d] got=%h exp=%h", i, d_gnt, pat[i]); end
        vec++; if (if_gnt !== !pat[i]) begin err++; $display("FAIL cont_if_gnt[%0d] got=%h exp=%h", i, if_gnt, !pat[i]); end
        vec++; if (mem_addr !== (pat[i] ? 32'h80 : 32'h40)) begin err++; $display("FAIL cont_mem_addr[%0d] got=%h", i, mem_addr); end
      end
      vec++; if (d_rvalid !== pd) begin err++; $display("FAIL cont_d_rvalid[%0d] got=%h exp=%h", i, d_rvalid, pd); end
      vec++; if (if_rvalid !== pf) begin err++; $display("FAIL cont_if_rvalid[%0d] got=%h exp=%h", i, if_rvalid, pf); end
      if (pd) begin vec++; if (d_rdata !== 32'hA000_0020) begin err++; $display("FAIL cont_d_rdata[%0d] got=%h exp=a0000020", i, d_rdata); end end
      if (pf) begin vec++; if (if_rdata !== 32'hA000_0010) begin err++; $display("FAIL cont_if_rdata[%0d] got=%h exp=a0000010", i, if_rdata); end end
      pd = (i < 10) && pat[i];
      pf = (i < 10) && !pat[i];
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b1; d_we = 4'hF; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; #1;
    vec++; if (d_gnt !== 1'b1) begin err++; $display("FAIL st_d_gnt got=%h exp=1", d_gnt); end
    vec++; if (mem_we !== 4'hF || mem_addr !== 32'h100) begin err++; $display("FAIL st_mem got we=%h addr=%h exp we=f addr=100", mem_we, mem_addr); end
    vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL st_mem_wdata got=%h exp=deadbeef", mem_wdata); end
    @(negedge clk);
    d_we = 4'h0; d_wdata = 32'h0; #1;
    vec++; if (d_rvalid !== 1'b0) begin err++; $display("FAIL st_no_rvalid got=%h exp=0", d_rvalid); end
    vec++; if (d_gnt !== 1'b1 || mem_we !== 4'h0) begin err++; $display("FAIL ld_gnt got gnt=%h we=%h exp 1/0", d_gnt, mem_we); end
    @(negedge clk);
    d_req = 1'b0; #1;
    vec++; if (d_rvalid !== 1'b1) begin err++; $display("FAIL ld_rvalid got=%h exp=1", d_rvalid); end
    vec++; if (d_rdata !== 32'hDEAD_BEEF) begin err++; $display("FAIL ld_rdata got=%h exp=deadbeef", d_rdata); end
  endtask

  task automatic test_flush_kill();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b0; flush = 1'b0; #1;
    vec++; if (if_gnt !== 1'b1) begin err++; $display("FAIL fk_if_gnt got=%h exp=1", if_gnt); end
    @(negedge clk);
    flush = 1'b1; #1;
    vec++; if (if_rvalid !== 1'b0) begin err++; $display("FAIL fk_if_rvalid got=%h exp=0", if_rvalid); end
    vec++; if (if_gnt !== 1'b0 || mem_en !== 1'b0) begin err++; $display("FAIL fk_flush_gnt got=%b%b exp=00", if_gnt, mem_en); end
    @(negedge clk);
    flush = 1'b0; #1;
    vec++; if (if_rvalid !== 1'b0) begin err++; $display("FAIL fk_after_rvalid got=%h exp=0", if_rvalid); end
    vec++; if (if_gnt !== 1'b1) begin err++; $display("FAIL fk_regrant got=%h exp=1", if_gnt); end
    @(negedge clk);
    if_req = 1'b0; #1;
    vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA000_0010) begin err++; $display("FAIL fk_resp got v=%h d=%h exp 1/a0000010", if_rvalid, if_rdata); end
  endtask

  task automatic test_flush_data();
    logic [4:0] pat;
    pat = 5'b01111;
    @(negedge clk);
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h80; if_req = 1'b0; #1;
    vec++; if (d_gnt !== 1'b1) begin err++; $display("FAIL fd_d_gnt got=%h exp=1", d_gnt); end
    @(negedge clk);
    d_req = 1'b0; flush = 1'b1; if_req = 1'b1; if_addr = 32'h40; #1;
    vec++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA000_0020) begin err++; $display("FAIL fd_d_resp got v=%h d=%h exp 1/a0000020", d_rvalid, d_rdata); end
    vec++; if (if_gnt !== 1'b0) begin err++; $display("FAIL fd_if_gnt got=%h exp=0", if_gnt); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'b0; d_req = 1'b1; #1;
      vec++; if (d_gnt !== 1'b1) begin err++; $display("FAIL fd_build[%0d] got=%h exp=1", i, d_gnt); end
    end
    @(negedge clk);
    flush = 1'b1; #1;
    vec++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin err++; $display("FAIL fd_flush_gnt got d=%h f=%h exp 1/0", d_gnt, if_gnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      flush = 1'b0; #1;
      vec++; if (d_gnt !== pat[i] || if_gnt !== !pat[i]) begin err++; $display("FAIL fd_after[%0d] got d=%h f=%h exp d=%h", i, d_gnt, if_gnt, pat[i]); end
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_contention();
    test_store_load();
    test_flush_kill();
    test_flush_data();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
